cellrv32_wb_sram_responder: RTL and testbench

//  Wishbone responder (slave) that terminates the external bus gateway of the CPU.

---
 rtl/cellrv32_wb_sram_responder.sv | 151 +++++++++++++++
 tb/tb_cellrv32_wb_sram_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cellrv32_wb_sram_responder.sv
// Wishbone responder backed by a word-organised RAM with byte-lane writes.
// A request is latched in IDLE. The termination (ack or err) is driven from
// flops exactly LATENCY cycles after the edge that sampled the request.
// The responder rejects out-of-range addresses. When RO_UNPRIV is set, it also
// rejects unprivileged writes.
module cellrv32_wb_sram_responder #(
  parameter int          MEM_SIZE  = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LATENCY   = 1,
  parameter bit          PIPE_MODE = 1'b0,
  parameter bit          RO_UNPRIV = 1'b0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [2:0]  wb_tag_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        busy_o
);

  localparam int         AW     = $clog2(MEM_SIZE);
  localparam int         WORDS  = MEM_SIZE / 4;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] adr_r, wdat_r;
  logic        we_r, priv_r;
  logic [3:0]  sel_r;
  logic        req_s, resp_s, err_s, in_range_s, wr_s;
  logic        ack_r, err_r;
  logic [31:0] rdat_r;
  logic [31:0] mem_r [WORDS];
  logic        unused_s;

  // Secure/fetch tag bits and the byte offset carry no meaning for this memory.
  assign unused_s = ^{wb_tag_i[2:1], adr_r[1:0]};

  // In both modes, stb is only looked at in IDLE. A classic level request is
  // therefore taken once. A pipelined strobe issued while busy is dropped.
  generate
    if (PIPE_MODE) begin : g_pipe
      assign req_s = wb_cyc_i & wb_stb_i;
    end else begin : g_classic
      assign req_s = wb_cyc_i & wb_stb_i;
    end
  endgenerate

  assign in_range_s = (adr_r[31:AW] == BASE_ADDR[31:AW]);
  assign err_s      = ~in_range_s | (RO_UNPRIV & we_r & ~priv_r);
  assign wr_s       = resp_s & ~err_s & we_r;

  // Next-state logic: latency countdown, abort on cyc drop, single response.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    resp_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          cnt_nxt_s   = LAT_M1;
          state_nxt_s = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
          end
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
        if (wb_cyc_i) begin
          resp_s = 1'b1;
        end else begin
          resp_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter, latched request and registered response outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      adr_r   <= 32'd0;
      wdat_r  <= 32'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      priv_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdat_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == IDLE) && req_s) begin
        adr_r  <= wb_adr_i;
        wdat_r <= wb_dat_i;
        we_r   <= wb_we_i;
        sel_r  <= wb_sel_i;
        priv_r <= wb_tag_i[0];
      end
      ack_r  <= resp_s & ~err_s;
      err_r  <= resp_s & err_s;
      rdat_r <= (resp_s && !err_s && !we_r) ? mem_r[adr_r[AW-1:2]] : 32'd0;
    end
  end

  // RAM byte-lane write on the edge that raises ack; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_r[i]) begin
          mem_r[adr_r[AW-1:2]][8*i +: 8] <= wdat_r[8*i +: 8];
        end
      end
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_err_o = err_r;
  assign wb_dat_o = rdat_r;
  assign busy_o   = (state_r != IDLE);

endmodule

// File: tb/tb_cellrv32_wb_sram_responder.sv
// Directed bench: u0 is classic, LATENCY=1, RO_UNPRIV=1; u1 is pipelined, LATENCY=4.
module tb_cellrv32_wb_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  tag = 3'b001;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic        stb = 1'b0;
  logic        cyc0 = 1'b0;
  logic        cyc1 = 1'b0;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, busy0, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cellrv32_wb_sram_responder #(
    .MEM_SIZE(4096), .BASE_ADDR(BASE), .LATENCY(1), .PIPE_MODE(1'b0), .RO_UNPRIV(1'b1)
  ) u0 (
    .clk_i(clk), .rstn_i(rstn), .wb_tag_i(tag), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc0),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .busy_o(busy0)
  );

  cellrv32_wb_sram_responder #(
    .MEM_SIZE(4096), .BASE_ADDR(BASE), .LATENCY(4), .PIPE_MODE(1'b1), .RO_UNPRIV(1'b0)
  ) u1 (
    .clk_i(clk), .rstn_i(rstn), .wb_tag_i(tag), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc1),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .busy_o(busy1)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Classic transfer on u0: cyc/stb held until the response, then dropped.
  task automatic classic0(input string name, input logic w, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic x_ack, input logic x_err, input logic [31:0] x_dat);
    @(posedge clk); #1;
    tag = t; adr = a; dat = d; we = w; sel = s; stb = 1'b1; cyc0 = 1'b1;
    @(posedge clk); #1;
    chk({name, ".busy"}, {31'd0, busy0}, 32'd1);
    chk({name, ".early_ack"}, {31'd0, ack0 | err0}, 32'd0);
    chk({name, ".dat_idle"}, dat0, 32'd0);
    @(posedge clk); #1;
    chk({name, ".ack"}, {31'd0, ack0}, {31'd0, x_ack});
    chk({name, ".err"}, {31'd0, err0}, {31'd0, x_err});
    if (!w) chk({name, ".dat"}, dat0, x_dat);
    cyc0 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk({name, ".after"}, {dat0, ack0, err0, busy0} == 35'd0 ? 32'd0 : 32'd1, 32'd0);
  endtask

  // Pipelined transfer on u1: one-cycle stb, optional stray stb during WAIT.
  task automatic pipe1(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic x_ack, input logic x_err, input logic [31:0] x_dat,
                       input logic extra);
    @(posedge clk); #1;
    tag = 3'b001; adr = a; dat = d; we = w; sel = s; stb = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s.wait%0d", name, i), {30'd0, busy1, ack1 | err1}, 32'd2);
      if (extra && i == 1) begin
        stb = 1'b1; adr = BASE + 32'h20; dat = 32'h0BAD_BAD0; we = 1'b1; sel = 4'hF;
      end else begin
        stb = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk({name, ".ack"}, {31'd0, ack1}, {31'd0, x_ack});
    chk({name, ".err"}, {31'd0, err1}, {31'd0, x_err});
    chk({name, ".busy_end"}, {31'd0, busy1}, 32'd0);
    if (!w) chk({name, ".dat"}, dat1, x_dat);
    cyc1 = 1'b0;
    @(posedge clk); #1;
    chk({name, ".after"}, {29'd0, ack1, err1, busy1}, 32'd0);
    chk({name, ".dat_after"}, dat1, 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst.u0", {dat0, ack0, err0, busy0} == 35'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("rst.u1", {dat1, ack1, err1, busy1} == 35'd0 ? 32'd0 : 32'd1, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Test 1: full word write then read, latency 1
    classic0("t1.wr", 1'b1, 3'b001, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    classic0("t1.rd", 1'b0, 3'b001, BASE + 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF);
    // Test 2: single byte lane, then sel=0 write leaves word unchanged
    classic0("t2.wr", 1'b1, 3'b001, BASE + 32'h4, 32'h0000_00AA, 4'b0001, 1'b1, 1'b0, 32'h0);
    classic0("t2.rd", 1'b0, 3'b001, BASE + 32'h4, 32'h0, 4'b0010, 1'b1, 1'b0, 32'hDEAD_BEAA);
    classic0("t2.wr0", 1'b1, 3'b001, BASE + 32'h4, 32'h1234_5678, 4'b0000, 1'b1, 1'b0, 32'h0);
    classic0("t2.rd0", 1'b0, 3'b001, BASE + 32'h7, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEAD_BEAA);
    // Test 4: out-of-range read
    classic0("t4.oor", 1'b0, 3'b001, BASE + 32'd4096, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
    classic0("t4.low", 1'b0, 3'b001, BASE - 32'd4, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
    // Test 5: unprivileged write rejected, privileged write accepted
    classic0("t5.init", 1'b1, 3'b001, BASE + 32'h8, 32'h1111_1111, 4'hF, 1'b1, 1'b0, 32'h0);
    classic0("t5.uwr", 1'b1, 3'b000, BASE + 32'h8, 32'h2222_2222, 4'hF, 1'b0, 1'b1, 32'h0);
    classic0("t5.urd", 1'b0, 3'b000, BASE + 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, 32'h1111_1111);
    classic0("t5.mwr", 1'b1, 3'b001, BASE + 32'h8, 32'h2222_2222, 4'hF, 1'b1, 1'b0, 32'h0);
    classic0("t5.mrd", 1'b0, 3'b001, BASE + 32'h8, 32'h0, 4'hF, 1'b1, 1'b0, 32'h2222_2222);

    // Test 3: latency 4 pipelined, stray stb during WAIT ignored
    pipe1("t3.wr", 1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
    pipe1("t3.rd", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
    pipe1("t4.oor4", 1'b0, BASE + 32'd4096, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0);

    // Test 6a: cyc dropped in cycle 2 of a write
    @(posedge clk); #1;
    adr = BASE + 32'h10; dat = 32'hDEAD_0001; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; cyc1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t6.abort%0d", i), {30'd0, ack1, err1}, 32'd0);
    end
    chk("t6.abort_idle", {31'd0, busy1}, 32'd0);
    pipe1("t6.rd", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Test 6b: asynchronous reset mid-WAIT
    @(posedge clk); #1;
    adr = BASE + 32'h10; dat = 32'hDEAD_0002; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1;
    chk("t6.busy_pre", {31'd0, busy1}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6.rst_async", {dat1, ack1, err1, busy1} == 35'd0 ? 32'd0 : 32'd1, 32'd0);
    cyc1 = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t6.post_rst%0d", i), {29'd0, ack1, err1, busy1}, 32'd0);
    end
    pipe1("t6.rd2", 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
